// File: rtl/mem_pkg.sv
// mem_pkg: shared access-size and state encodings, wait counter width, alignment helper
package mem_pkg;
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_RSVD = 2'b11} size_e;
  typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_e;
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    return size == SZ_RSVD || (size == SZ_HALF && a[0]) || (size == SZ_WORD && a != 2'b00);
  endfunction
endpackage

// File: rtl/mem_lane.sv
// mem_lane: little-endian lane extract/extend for loads and lane merge for stores
module mem_lane
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [1:0]  lane,
  input  logic [31:0] rd_word,
  input  logic [31:0] buf_word,
  input  logic [31:0] wdata,
  output logic [31:0] ext_data,
  output logic [31:0] merged
);
  logic [4:0]  sh;
  logic [31:0] shifted;
  logic [31:0] mask;
  // shift addressed lanes down for loads, splice store data into the buffered word
  always_comb begin
    sh = {lane, 3'b000};
    shifted = rd_word >> sh;
    mask = size == SZ_BYTE ? 32'h0000_00FF << sh : size == SZ_HALF ? 32'h0000_FFFF << sh : 32'hFFFF_FFFF;
    ext_data = size == SZ_BYTE ? {{24{sgn & shifted[7]}}, shifted[7:0]} :
               size == SZ_HALF ? {{16{sgn & shifted[15]}}, shifted[15:0]} : rd_word;
    merged = (buf_word & ~mask) | ((wdata << sh) & mask);
  end
endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte/half/word load-store controller with read-modify-write over a word-wide memory
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int WAIT_CYCLES = 0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ,
  output logic        READY,
  input  logic        WE,
  input  logic [1:0]  SIZE,
  input  logic        SIGNED,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] WDATA,
  output logic [31:0] RDATA,
  output logic        DONE,
  output logic        FAULT,
  output logic [31:0] ADDR,
  output logic        N_OE,
  output logic        N_WE,
  output logic [31:0] MEM_WDATA,
  input  logic [31:0] MEM_RDATA
);
  state_e           state, next;
  size_e            c_size;
  logic [CNT_W-1:0] cnt;
  logic             c_we, c_sgn, c_fault, last;
  logic [31:0]      c_addr, c_wdata, buf_q, ext_data, merged;
  assign last = cnt == CNT_W'(WAIT_CYCLES);
  assign READY = state == IDLE && !RST;
  assign N_OE = state != RD;
  assign N_WE = state != WR;
  assign DONE = state == FIN && !c_fault;
  assign FAULT = state == FIN && c_fault;
  assign ADDR = {c_addr[31:2], 2'b00};
  assign MEM_WDATA = state == WR ? merged : '0;
  mem_lane u_lane (
    .size     (c_size),
    .sgn      (c_sgn),
    .lane     (c_addr[1:0]),
    .rd_word  (MEM_RDATA),
    .buf_word (buf_q),
    .wdata    (c_wdata),
    .ext_data (ext_data),
    .merged   (merged)
  );
  // state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else state <= next;
  end
  // faults skip the bus; sub-word stores read the word first so untouched lanes survive
  always_comb begin
    next = state == IDLE ? (!REQ ? IDLE : misaligned(SIZE, REQ_ADDR[1:0]) ? FIN : (WE && SIZE == SZ_WORD) ? WR : RD) :
           state == RD   ? (!last ? RD : c_we ? WR : FIN) :
           state == WR   ? (last ? FIN : WR) : IDLE;
  end
  // request capture, wait counter, read buffer and load result
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
      c_we <= 1'b0;
      c_sgn <= 1'b0;
      c_fault <= 1'b0;
      c_size <= SZ_BYTE;
      c_addr <= '0;
      c_wdata <= '0;
      buf_q <= '0;
      RDATA <= '0;
    end else begin
      if (state == IDLE && REQ) begin
        c_we <= WE;
        c_sgn <= SIGNED;
        c_size <= size_e'(SIZE);
        c_addr <= REQ_ADDR;
        c_wdata <= WDATA;
        c_fault <= misaligned(SIZE, REQ_ADDR[1:0]);
      end
      cnt <= (state == RD || state == WR) && !last ? cnt + 1'b1 : '0;
      if (state == RD && last) begin
        buf_q <= MEM_RDATA;
        if (!c_we) RDATA <= ext_data;
      end
    end
  end
endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter: WAIT_CYCLES, default 0, extra cycles N_OE/N_WE are held low per bus access (0..15).
REQ-002 SHALL have port: CLK  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: RST  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: REQ  in  1  request valid.
REQ-005 SHALL have port: READY  out  1  controller idle; request accepted on edge where REQ && READY.
REQ-006 SHALL have port: WE  in  1  1 = store, 0 = load.
REQ-007 SHALL have port: SIZE  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as fault).
REQ-008 SHALL have port: SIGNED  in  1  loads: sign-extend sub-word result.
REQ-009 SHALL have port: REQ_ADDR  in  32  byte address.
REQ-010 SHALL have port: WDATA  in  32  store data, right-aligned.
REQ-011 SHALL have port: RDATA  out  32  load result, right-aligned and extended.
REQ-012 SHALL have port: DONE  out  1  one-cycle completion pulse.
REQ-013 SHALL have port: FAULT  out  1  one-cycle misalignment/bad-size pulse; replaces DONE.
REQ-014 SHALL have port: ADDR  out  32  word address to memory, bits [1:0] always 0.
REQ-015 SHALL have port: N_OE  out  1  memory read enable, active-low.
REQ-016 SHALL have port: N_WE  out  1  memory write enable, active-low.
REQ-017 SHALL have port: MEM_WDATA  out  32  word to memory IN.
REQ-018 SHALL have port: MEM_RDATA  in  32  word from memory OUT.

Function
REQ-019 SHALL use states IDLE, RD, WR, FIN; READY=1 only in IDLE.
REQ-020 SHALL capture WE, SIZE, SIGNED, REQ_ADDR and WDATA on accept; later input changes have no effect. REQ outside IDLE is ignored.
REQ-021 Misalignment: half with addr[0]=1, word with addr[1:0]!=0, or SIZE=11 SHALL go IDLE->FIN with FAULT=1, DONE=0, no bus cycle.
REQ-022 Load: IDLE->RD->FIN. Word store: IDLE->WR->FIN. Sub-word store: IDLE->RD->WR->FIN (read-modify-write).
REQ-023 RD and WR SHALL each last 1+WAIT_CYCLES cycles, counted by an internal 4-bit counter. The last RD cycle captures MEM_RDATA into a word buffer on its closing edge.
REQ-024 N_OE SHALL be low exactly during RD, and N_WE low exactly during WR. Both SHALL be decoded from registered state; both are never low together.
REQ-025 ADDR SHALL be {captured_addr[31:2],2'b00} from accept until IDLE; it is stable across the RD->WR transition.
REQ-026 Lanes are little-endian: byte k = bits [8k+7:8k]; a half uses lanes {2a+1,2a} for a=addr[1].
REQ-027 WR SHALL drive MEM_WDATA as follows: word = WDATA; sub-word = word buffer with the addressed lanes replaced by WDATA low bits.
REQ-028 FIN SHALL last 1 cycle with DONE or FAULT=1 and READY=0, then return to IDLE. RDATA SHALL be valid in FIN and held until the next load's FIN.
REQ-029 Load extension: SIGNED=1 sign-extends from bit 7/15; otherwise zero-extends. Stores leave RDATA unchanged.
REQ-030 Word load latency: accept edge -> DONE high 2+WAIT_CYCLES cycles later. Sub-word store: 3+2*WAIT_CYCLES.
REQ-031 Back-to-back: the earliest next accept is the edge ending the first IDLE cycle after FIN.

Reset
REQ-032 RST asserted SHALL immediately force the following: state IDLE, N_OE=1, N_WE=1, ADDR=0, MEM_WDATA=0, RDATA=0, DONE=0, FAULT=0, counter=0, READY=0.
REQ-033 Reset mid-RD/WR SHALL abort the access with no DONE or FAULT. A partially completed RMW is not retried.
REQ-034 READY SHALL rise in the first cycle after RST deasserts.

Structure
REQ-035 SHALL place the SIZE encoding enum, the state enum and the WAIT counter width in shared package mem_pkg.
REQ-036 SHALL implement lane extract/merge/extend as combinational sub-module mem_lane, instantiated once.

Verification
REQ-037 Word load: memory word 0x100 = 0xDEADBEEF, REQ load word 0x100 -> N_OE low 1 cycle, ADDR=0x100, DONE next cycle, RDATA=0xDEADBEEF.
REQ-038 Signed byte load at 0x103 with word 0x80FF7F01 -> RDATA=0xFFFFFF80; unsigned -> 0x00000080.
REQ-039 Half store 0xABCD to 0x102 over 0x11223344 -> RD then WR, MEM_WDATA=0xABCD3344, DONE, ADDR constant 0x100.
REQ-040 Word load at 0x101 -> FAULT pulse, DONE=0, N_OE/N_WE never low; SIZE=11 -> FAULT.
REQ-041 WAIT_CYCLES=3 word store -> N_WE low exactly 4 cycles, DONE on 5th cycle after accept.
REQ-042 RST asserted in 2nd WR cycle -> N_WE high same cycle, no DONE, READY high one cycle after release.
